// File: rtl/conv_job_scheduler_if.sv
// Scheduler bus: two-requester descriptor intake, coprocessor cfg/start/done, completion record.
// master = scheduler side, slave = system/coprocessor side.
interface conv_job_scheduler_if #(
  parameter int ADDR_W = 5,
  parameter int SIZE_W = 5,
  parameter int TAG_W  = 4
);
  localparam int DESC_W = 3*ADDR_W + 2*SIZE_W + TAG_W;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DESC_W-1:0] req_desc;
  logic [ADDR_W-1:0]   cfg_addrX;
  logic [ADDR_W-1:0]   cfg_addrY;
  logic [ADDR_W-1:0]   cfg_addrZ;
  logic [SIZE_W-1:0]   cfg_sizeX;
  logic [SIZE_W-1:0]   cfg_sizeY;
  logic                copro_start;
  logic                copro_busy;
  logic                copro_done;
  logic                copro_abort;
  logic                cmpl_valid;
  logic                cmpl_ready;
  logic [TAG_W-1:0]    cmpl_tag;
  logic                cmpl_src;
  logic [1:0]          cmpl_err;

  modport master (
    input  req_valid, req_desc, copro_busy, copro_done, cmpl_ready,
    output req_ready, cfg_addrX, cfg_addrY, cfg_addrZ, cfg_sizeX, cfg_sizeY,
           copro_start, copro_abort, cmpl_valid, cmpl_tag, cmpl_src, cmpl_err
  );

  modport slave (
    output req_valid, req_desc, copro_busy, copro_done, cmpl_ready,
    input  req_ready, cfg_addrX, cfg_addrY, cfg_addrZ, cfg_sizeX, cfg_sizeY,
           copro_start, copro_abort, cmpl_valid, cmpl_tag, cmpl_src, cmpl_err
  );
endinterface

// File: rtl/conv_job_scheduler.sv
// Round-robin job scheduler for the conv coprocessor: start 1 cycle after accept, completion 1 cycle after done;
// holds in START while copro busy and in CMPL until cmpl_ready. Watchdog abort under CONV_SCHED_TIMEOUT_EN.
module conv_job_scheduler #(
  parameter int ADDR_W         = 5,
  parameter int SIZE_W         = 5,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rstn,
  conv_job_scheduler_if.master bus,
  output logic                 sched_busy,
  output logic [15:0]          job_count
);
  localparam int DESC_W = 3*ADDR_W + 2*SIZE_W + TAG_W;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [SIZE_W-1:0] size_y;
    logic [SIZE_W-1:0] size_x;
    logic [ADDR_W-1:0] addr_z;
    logic [ADDR_W-1:0] addr_y;
    logic [ADDR_W-1:0] addr_x;
  } desc_t;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CMPL} state_t;

  state_t            r_state, w_nxt_state;
  logic              r_rr;
  logic              r_src;
  logic [TAG_W-1:0]  r_tag;
  logic [1:0]        r_err, w_nxt_err;
  logic [ADDR_W-1:0] r_addr_x, r_addr_y, r_addr_z;
  logic [SIZE_W-1:0] r_size_x, r_size_y;
  logic [15:0]       r_job_count;
  logic              w_gnt, w_gnt_vld, w_accept, w_cmpl_hs, w_timeout;
  desc_t             w_desc;

  always_comb begin
    w_gnt_vld = |bus.req_valid;
    case (bus.req_valid)
      2'b10:   w_gnt = 1'b1;
      2'b11:   w_gnt = r_rr;
      default: w_gnt = 1'b0;
    endcase
  end

  assign w_desc = w_gnt ? desc_t'(bus.req_desc[2*DESC_W-1:DESC_W])
                        : desc_t'(bus.req_desc[DESC_W-1:0]);

`ifdef CONV_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Cleared while in START so it reads zero on the first WAIT cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  r_to_cnt <= '0;
    else if (r_state == S_START) r_to_cnt <= '0;
    else if (r_state == S_WAIT)  r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == S_WAIT) && !bus.copro_done &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  assign bus.copro_abort = w_timeout;

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_err       = r_err;
    w_accept        = 1'b0;
    w_cmpl_hs       = 1'b0;
    bus.copro_start = 1'b0;
    bus.req_ready   = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          bus.req_ready[w_gnt] = 1'b1;
          w_accept             = 1'b1;
          if (w_desc.size_x == '0 || w_desc.size_y == '0) begin
            w_nxt_state = S_CMPL;
            w_nxt_err   = 2'd1;
          end else begin
            w_nxt_state = S_START;
          end
        end
      end
      S_START: begin
        if (!bus.copro_busy) begin
          bus.copro_start = 1'b1;
          w_nxt_state     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.copro_done) begin
          w_nxt_state = S_CMPL;
          w_nxt_err   = 2'd0;
        end else if (w_timeout) begin
          w_nxt_state = S_CMPL;
          w_nxt_err   = 2'd2;
        end
      end
      S_CMPL: begin
        if (bus.cmpl_ready) begin
          w_cmpl_hs   = 1'b1;
          w_nxt_state = S_IDLE;
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b0;
      r_src       <= 1'b0;
      r_tag       <= '0;
      r_err       <= 2'd0;
      r_addr_x    <= '0;
      r_addr_y    <= '0;
      r_addr_z    <= '0;
      r_size_x    <= '0;
      r_size_y    <= '0;
      r_job_count <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_err   <= w_nxt_err;
      if (w_accept) begin
        r_addr_x <= w_desc.addr_x;
        r_addr_y <= w_desc.addr_y;
        r_addr_z <= w_desc.addr_z;
        r_size_x <= w_desc.size_x;
        r_size_y <= w_desc.size_y;
        r_tag    <= w_desc.tag;
        r_src    <= w_gnt;
        r_rr     <= ~w_gnt;
      end
      if (w_cmpl_hs) r_job_count <= r_job_count + 16'd1;
    end
  end

  assign bus.cfg_addrX  = r_addr_x;
  assign bus.cfg_addrY  = r_addr_y;
  assign bus.cfg_addrZ  = r_addr_z;
  assign bus.cfg_sizeX  = r_size_x;
  assign bus.cfg_sizeY  = r_size_y;
  assign bus.cmpl_valid = (r_state == S_CMPL);
  assign bus.cmpl_tag   = r_tag;
  assign bus.cmpl_src   = r_src;
  assign bus.cmpl_err   = r_err;
  assign sched_busy     = (r_state != S_IDLE);
  assign job_count      = r_job_count;
endmodule
